bias_add_sequencer: RTL and testbench

- Sequences bias application for one conv layer's output stream.
- Holds the flattened bias banks for every output-channel group. One group is N_adder_tree lanes of 18-bit signed bias constants, provided by the per-layer BIAS bank modules.
- Accepts adder-tree partial-sum beats through a valid/ready handshake and adds the current group's bias lane-wise with saturation.
- Advances the group after every PIX_PER_GROUP beats and signals completion when the layer is finished. Sits between the adder tree and the activation/requant stage.

---
 rtl/bias_add_sequencer_if.sv | 23 ++
 rtl/bias_add_sequencer.sv | 109 ++++++++++
 tb/tb_bias_add_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_add_sequencer_if.sv
// Partial-sum input stream and biased output stream between the adder tree,
// the bias sequencer and the activation stage.
interface bias_add_sequencer_if #(
  parameter int N_adder_tree = 16,
  parameter int DATA_W       = 18
) ();
  logic [N_adder_tree*DATA_W-1:0] acc_in;
  logic                           acc_valid;
  logic                           acc_ready;
  logic [N_adder_tree*DATA_W-1:0] out_data;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    output acc_in, acc_valid, out_ready,
    input  acc_ready, out_data, out_valid
  );

  modport slave (
    input  acc_in, acc_valid, out_ready,
    output acc_ready, out_data, out_valid
  );
endinterface

// File: rtl/bias_add_sequencer.sv
// Adds the current output-channel group's bias to each adder-tree beat with
// saturation, stepping through the groups of one conv layer pass.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | accepting beats, applying the current group's bias
// FINISH | last beat taken, waiting for the final result to drain
module bias_add_sequencer #(
  parameter int N_adder_tree  = 16,
  parameter int DATA_W        = 18,
  parameter int NUM_GROUPS    = 4,
  parameter int PIX_PER_GROUP = 16,
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [NUM_GROUPS*N_adder_tree*DATA_W-1:0] bias_bank,
  bias_add_sequencer_if.slave                      stream,
  output logic [GW-1:0]                            group_idx,
  output logic                                     busy,
  output logic                                     done
);

  localparam int PW      = (PIX_PER_GROUP > 1) ? $clog2(PIX_PER_GROUP) : 1;
  localparam int GROUP_W = N_adder_tree * DATA_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]         state;
  logic [PW-1:0]      pix_cnt;
  logic               accept;
  logic               last_pix;
  logic               last_group;
  logic [GROUP_W-1:0] group_bias;
  logic [GROUP_W-1:0] biased;

  assign stream.acc_ready = (state == S_RUN) && (!stream.out_valid || stream.out_ready);
  assign accept     = stream.acc_valid && stream.acc_ready;
  assign last_pix   = (pix_cnt == PW'(PIX_PER_GROUP - 1));
  assign last_group = (group_idx == GW'(NUM_GROUPS - 1));
  assign busy       = (state != S_IDLE) || stream.out_valid;
  assign done       = (state == S_FINISH) && !stream.out_valid;

  // Bias is taken from the group in force before this beat's counter update.
  assign group_bias = bias_bank[int'(group_idx) * GROUP_W +: GROUP_W];

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    logic [DATA_W-1:0] acc_l;
    logic [DATA_W-1:0] bias_l;
    logic [DATA_W:0]   sum;

    assign acc_l  = stream.acc_in[DATA_W*i +: DATA_W];
    assign bias_l = group_bias[DATA_W*i +: DATA_W];
    assign sum    = {acc_l[DATA_W-1], acc_l} + {bias_l[DATA_W-1], bias_l};
    // Top two bits disagree only when the 19-bit sum left the 18-bit range.
    assign biased[DATA_W*i +: DATA_W] =
      (sum[DATA_W] == sum[DATA_W-1]) ? sum[DATA_W-1:0] :
      (sum[DATA_W] ? SAT_MIN : SAT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      pix_cnt          <= '0;
      group_idx        <= '0;
      stream.out_valid <= 1'b0;
      stream.out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            pix_cnt   <= '0;
            group_idx <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (last_pix) begin
              pix_cnt   <= '0;
              group_idx <= last_group ? '0 : group_idx + 1'b1;
              if (last_group) state <= S_FINISH;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        S_FINISH: begin
          if (!stream.out_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        stream.out_data  <= biased;
        stream.out_valid <= 1'b1;
      end else if (stream.out_ready) begin
        stream.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bias_add_sequencer.sv
// Directed and randomised bench for bias_add_sequencer: reset, bias add,
// saturation, group stepping, backpressure and mid-pass abort.
module tb_bias_add_sequencer;

  localparam int N   = 16;
  localparam int DW  = 18;
  localparam int NG  = 4;
  localparam int PPG = 16;
  localparam int BW  = N * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NG*BW-1:0] bias_bank;
  logic [1:0]      group_idx;
  logic            busy;
  logic            done;

  bias_add_sequencer_if #(.N_adder_tree(N), .DATA_W(DW)) sif ();

  bias_add_sequencer #(
    .N_adder_tree(N), .DATA_W(DW), .NUM_GROUPS(NG), .PIX_PER_GROUP(PPG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bias_bank(bias_bank),
    .stream(sif), .group_idx(group_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int             m_state;
  int             m_pix;
  int             m_grp;
  logic           m_ov;
  logic [BW-1:0]  m_out;
  int             accepts;
  int             done_seen;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > (1 << (DW-1)) - 1) return 18'h1FFFF;
    if (s < -(1 << (DW-1)))    return 18'h20000;
    return s[DW-1:0];
  endfunction

  function automatic logic [BW-1:0] model_beat(input logic [BW-1:0] acc, input int g);
    logic [BW-1:0] r;
    for (int i = 0; i < N; i++)
      r[DW*i +: DW] = sat_add(acc[DW*i +: DW], bias_bank[(g*N + i)*DW +: DW]);
    return r;
  endfunction

  task automatic m_reset();
    m_state = 0; m_pix = 0; m_grp = 0; m_ov = 1'b0; m_out = '0;
  endtask

  // Called at posedge+1: compares outputs to the model, crosses one edge,
  // advances the model, and returns at posedge+1 for the next drive.
  task automatic cyc();
    logic exp_ready;
    logic acc_now;
    int   g_before;
    #1;
    exp_ready = (m_state == 1) && (!m_ov || sif.out_ready);
    check("acc_ready", sif.acc_ready, exp_ready);
    check("out_valid", sif.out_valid, m_ov);
    check("group_idx", group_idx, m_grp[1:0]);
    check("done", done, (m_state == 2) && !m_ov);
    check("busy", busy, (m_state != 0) || m_ov);
    if (m_ov) check("out_data", sif.out_data, m_out);
    if (done) done_seen++;
    acc_now  = sif.acc_valid && exp_ready;
    g_before = m_grp;
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      case (m_state)
        0: if (start) begin m_state = 1; m_pix = 0; m_grp = 0; end
        1: if (acc_now) begin
             accepts++;
             if (m_pix == PPG-1) begin
               m_pix = 0;
               if (m_grp == NG-1) begin m_grp = 0; m_state = 2; end
               else m_grp++;
             end else begin
               m_pix++;
             end
           end
        2: if (!m_ov) m_state = 0;
        default: m_state = 0;
      endcase
      if (acc_now) begin
        m_out = model_beat(sif.acc_in, g_before);
        m_ov  = 1'b1;
      end else if (sif.out_ready) begin
        m_ov = 1'b0;
      end
    end
    #1;
  endtask

  task automatic rand_acc();
    for (int k = 0; k < BW/32; k++) sif.acc_in[32*k +: 32] = $urandom();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int            last_acc;
    int            stall_left;
    logic          stalled_once;
    logic [BW-1:0] stall_exp;
    logic [BW-1:0] acc;
    int            v;

    rst = 1'b1; start = 1'b0;
    sif.acc_valid = 1'b0; sif.acc_in = '0; sif.out_ready = 1'b1;
    bias_bank = '0;
    bias_bank[0*DW +: DW] = 18'b000011101000110000;   // 14896
    bias_bank[1*DW +: DW] = 18'h3FE14;                // -492
    bias_bank[2*DW +: DW] = 18'h3FE14;                // -492
    for (int i = 3; i < N; i++) bias_bank[i*DW +: DW] = 18'(i * 3);
    for (int k = BW/32; k < NG*BW/32; k++) bias_bank[32*k +: 32] = $urandom();
    m_reset();
    accepts = 0; done_seen = 0;

    // Reset and idle
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 1'b0;
    sif.acc_valid = 1'b1; rand_acc();
    repeat (3) cyc();
    sif.acc_valid = 1'b0;

    // Pass 1: directed bias/saturation beats, then back-to-back stream
    start = 1'b1; cyc(); start = 1'b0;
    acc = '0; acc[0 +: DW] = 18'd100;
    sif.acc_in = acc; sif.acc_valid = 1'b1;
    cyc();
    check("basic_lane0", sif.out_data[0 +: DW], 18'd14996);
    check("basic_lane2", sif.out_data[2*DW +: DW], 18'h3FE14);
    acc = '0; acc[0 +: DW] = 18'd131000; acc[DW +: DW] = 18'(-131000);
    sif.acc_in = acc;
    cyc();
    check("sat_pos_lane0", sif.out_data[0 +: DW], 18'h1FFFF);
    check("sat_neg_lane1", sif.out_data[DW +: DW], 18'h20000);

    last_acc = accepts;
    for (int c = 0; c < 400 && !(m_state == 0 && accepts >= NG*PPG); c++) begin
      sif.acc_valid = (accepts < NG*PPG);
      for (int i = 0; i < N; i++) begin
        v = (accepts + 1) * 531 - i * 977;
        sif.acc_in[DW*i +: DW] = v[DW-1:0];
      end
      cyc();
      if (accepts != last_acc) begin
        last_acc = accepts;
        case (accepts)
          15: check("grp_after15", group_idx, 2'd0);
          16: check("grp_after16", group_idx, 2'd1);
          48: check("grp_after48", group_idx, 2'd3);
          63: check("grp_after63", group_idx, 2'd3);
          64: check("grp_after64", group_idx, 2'd0);
          default: ;
        endcase
      end
    end
    check("pass1_done_once", done_seen, 1);
    sif.acc_valid = 1'b1;
    #1;
    check("pass1_idle_ready", sif.acc_ready, 1'b0);
    cyc();
    sif.acc_valid = 1'b0;

    // Pass 2: random beats, random out_ready, one 5-cycle stall
    accepts = 0; done_seen = 0; stall_left = 0; stalled_once = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 0; c < 2000 && !(m_state == 0 && accepts >= NG*PPG); c++) begin
      rand_acc();
      if (!stalled_once && accepts >= 20 && m_ov) begin
        stalled_once = 1'b1; stall_left = 5; stall_exp = m_out;
      end
      if (stall_left > 0) begin
        sif.acc_valid = 1'b1;
        sif.out_ready = 1'b0;
        #1;
        check("stall_ready", sif.acc_ready, 1'b0);
        check("stall_data", sif.out_data, stall_exp);
        stall_left--;
      end else begin
        sif.acc_valid = (accepts < NG*PPG) && ($urandom_range(0, 3) != 0);
        sif.out_ready = ($urandom_range(0, 4) != 0);
      end
      cyc();
    end
    check("pass2_beats", accepts, NG*PPG);
    check("pass2_done_once", done_seen, 1);
    sif.acc_valid = 1'b0; sif.out_ready = 1'b1;

    // Pass 3: abort at beat 30, then restart from group 0
    accepts = 0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 0; c < 200 && accepts < 30; c++) begin
      sif.acc_valid = 1'b1; rand_acc();
      cyc();
    end
    check("abort_grp_before", group_idx, 2'd1);
    rst = 1'b1; sif.acc_valid = 1'b0;
    cyc();
    check("abort_out_valid", sif.out_valid, 1'b0);
    check("abort_grp", group_idx, 2'd0);
    rst = 1'b0;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    acc = '0; acc[0 +: DW] = 18'd5;
    sif.acc_in = acc; sif.acc_valid = 1'b1;
    cyc();
    sif.acc_valid = 1'b0;
    check("restart_lane0", sif.out_data[0 +: DW], 18'd14901);
    check("restart_grp", group_idx, 2'd0);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
